// File: rtl/r22sdf_seq.sv
// ============================================================================
// Module   : r22sdf_seq
// Brief    : Frame sequencer for a radix-2^2 SDF FFT pipeline: datapath
//            enable, per-stage butterfly selects, fill tracking and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module r22sdf_seq #(
    parameter int FFT_LOG2      = 6,
    parameter int REG_PER_STAGE = 0
) (
    input  logic                sys_clk,
    input  logic                sys_nrst,
    input  logic                in_valid,
    input  logic                in_sop,
    output logic                in_ready,
    input  logic                flush_req,
    output logic                dp_en,
    output logic                din_zero,
    output logic [FFT_LOG2-1:0] stage_sel,
    output logic                out_valid,
    output logic                out_sop,
    output logic                sop_err,
    output logic                busy
);

    localparam int N = 1 << FFT_LOG2;

    // Cumulative delay in front of butterfly stage k.
    function automatic int d_of(input int k);
        int acc;
        acc = 0;
        for (int j = 0; j < k; j++) begin
            acc = acc + (N >> (j + 1)) + REG_PER_STAGE;
        end
        return acc;
    endfunction

    localparam int PIPE_LAT = d_of(FFT_LOG2);
    localparam int FILL_W   = $clog2(PIPE_LAT + 1);

    localparam logic [FILL_W-1:0]   c_fill_max   = FILL_W'(PIPE_LAT);
    localparam logic [FILL_W-1:0]   c_flush_last = FILL_W'(PIPE_LAT - 1);
    localparam logic [FFT_LOG2-1:0] c_cnt_last   = FFT_LOG2'(N - 1);
    localparam logic [FFT_LOG2-1:0] c_cnt_one    = FFT_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FFT_LOG2-1:0] r_cnt;
    logic [FFT_LOG2-1:0] w_cnt_nxt;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic [FFT_LOG2-1:0] r_out_cnt;
    logic [FFT_LOG2-1:0] w_out_cnt_nxt;
    logic [FILL_W-1:0]   r_flush_cnt;
    logic [FILL_W-1:0]   w_flush_cnt_nxt;
    logic                r_flush_pend;
    logic                w_flush_pend_nxt;
    logic                w_primed;
    logic                w_resync;
    logic                w_clear;

    assign w_primed = (r_fill == c_fill_max);
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_fill       <= '0;
            r_out_cnt    <= '0;
            r_flush_cnt  <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fill       <= w_fill_nxt;
            r_out_cnt    <= w_out_cnt_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_fill_nxt       = r_fill;
        w_out_cnt_nxt    = r_out_cnt;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_flush_pend_nxt = r_flush_pend;
        w_resync         = 1'b0;
        w_clear          = 1'b0;
        in_ready         = 1'b0;
        dp_en            = 1'b0;
        din_zero         = 1'b0;
        sop_err          = 1'b0;
        out_valid        = 1'b0;
        out_sop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                // Async reset forces IDLE, so only this state needs the
                // reset gate to keep the combinational outputs quiet.
                if (in_valid && sys_nrst) begin
                    if (in_sop) begin
                        dp_en       = 1'b1;
                        w_cnt_nxt   = c_cnt_one;
                        w_state_nxt = S_RUN;
                    end else begin
                        sop_err = 1'b1;
                    end
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                dp_en    = in_valid;
                if (flush_req) begin
                    w_flush_pend_nxt = 1'b1;
                end
                if (dp_en) begin
                    if (in_sop && (r_cnt != '0)) begin
                        sop_err   = 1'b1;
                        w_resync  = 1'b1;
                        w_cnt_nxt = c_cnt_one;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if ((r_cnt == c_cnt_last) && (r_flush_pend || flush_req)) begin
                            w_state_nxt      = S_FLUSH;
                            w_flush_pend_nxt = 1'b0;
                            w_flush_cnt_nxt  = '0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                dp_en           = 1'b1;
                din_zero        = 1'b1;
                w_cnt_nxt       = r_cnt + 1'b1;
                w_flush_cnt_nxt = r_flush_cnt + 1'b1;
                if (r_flush_cnt == c_flush_last) begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clear     = 1'b1;
            end
        endcase

        out_valid = dp_en & w_primed;
        out_sop   = out_valid & (r_out_cnt == '0);

        if (w_clear) begin
            w_fill_nxt       = '0;
            w_out_cnt_nxt    = '0;
            w_cnt_nxt        = '0;
            w_flush_pend_nxt = 1'b0;
            w_flush_cnt_nxt  = '0;
        end else if (w_resync) begin
            w_fill_nxt    = FILL_W'(1);
            w_out_cnt_nxt = '0;
        end else begin
            if (dp_en && !w_primed) begin
                w_fill_nxt = r_fill + 1'b1;
            end
            if (out_valid) begin
                w_out_cnt_nxt = r_out_cnt + 1'b1;
            end
        end
    end

    // Each stage sees the frame counter delayed by the pipeline ahead of it.
    for (genvar k = 0; k < FFT_LOG2; k++) begin : g_stage
        localparam int c_off = d_of(k) % N;
        logic [FFT_LOG2-1:0] w_rel;
        assign w_rel        = r_cnt - FFT_LOG2'(c_off);
        assign stage_sel[k] = w_rel[FFT_LOG2-1-k];
    end

endmodule

`default_nettype wire

// File: tb/tb_r22sdf_seq.sv
// ============================================================================
// Module   : tb_r22sdf_seq
// Brief    : Directed self-checking bench for r22sdf_seq at N=16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_r22sdf_seq;

    logic       sys_clk   = 1'b0;
    logic       sys_nrst  = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_sop    = 1'b0;
    logic       flush_req = 1'b0;
    logic       in_ready;
    logic       dp_en;
    logic       din_zero;
    logic [3:0] stage_sel;
    logic       out_valid;
    logic       out_sop;
    logic       sop_err;
    logic       busy;
    logic [10:0] obs;

    int n_pass  = 0;
    int n_total = 0;

    r22sdf_seq #(
        .FFT_LOG2      (4),
        .REG_PER_STAGE (0)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_nrst  (sys_nrst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_ready  (in_ready),
        .flush_req (flush_req),
        .dp_en     (dp_en),
        .din_zero  (din_zero),
        .stage_sel (stage_sel),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .sop_err   (sop_err),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    assign obs = {in_ready, busy, dp_en, din_zero, out_valid, out_sop, sop_err, stage_sel};

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (rdy,bsy,en,zero,ov,osop,err,sel)",
                      tag, got, exp);
    endtask

    // stage k select = bit (3-k) of (cnt - D(k)) mod 16, D = 0,8,12,14
    function automatic logic [3:0] exp_sel(input int c);
        logic [3:0] s;
        int off;
        int r;
        for (int k = 0; k < 4; k++) begin
            off  = (k == 0) ? 0 : (k == 1) ? 8 : (k == 2) ? 12 : 14;
            r    = (c - off + 16) % 16;
            s[k] = r[3-k];
        end
        return s;
    endfunction

    function automatic logic [10:0] ev(input logic rdy, bsy, en, dz, ov, os, se,
                                       input logic [3:0] sel);
        return {rdy, bsy, en, dz, ov, os, se, sel};
    endfunction

    task automatic step(input logic v, s, f, input string tag, input logic [10:0] exp);
        in_valid  = v;
        in_sop    = s;
        flush_req = f;
        @(negedge sys_clk);
        check(tag, obs, exp);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        flush_req = 1'b0;
        sys_nrst  = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_nrst  = 1'b1;
    endtask

    // Sample i of a fresh stream: output valid from i=15, sop every 16 outputs.
    task automatic run_frames(input int n, input int flush_at, input bit toggle);
        logic ov, os;
        for (int i = 0; i < n; i++) begin
            ov = (i >= 15);
            os = ov && (((i - 15) % 16) == 0);
            step(1'b1, (i % 16) == 0, i == flush_at, "run",
                 ev(1'b1, i != 0, 1'b1, 1'b0, ov, os, 1'b0, exp_sel(i % 16)));
            if (toggle)
                step(1'b0, 1'b0, 1'b0, "stall",
                     ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_sel((i + 1) % 16)));
        end
    endtask

    task automatic flush_drain();
        for (int f = 0; f < 15; f++)
            step(1'b1, 1'b1, 1'b0, "flush",
                 ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, exp_sel(f)));
        step(1'b0, 1'b0, 1'b0, "flush_idle",
             ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        @(posedge sys_clk);
        #1;
        step(1'b0, 1'b0, 1'b0, "reset", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
        step(1'b1, 1'b0, 1'b0, "reset_in", ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
        sys_nrst = 1'b1;

        // three continuous frames
        run_frames(48, -1, 1'b0);

        // same stream with alternating stalls
        do_reset();
        run_frames(48, -1, 1'b1);

        // flush requested at cnt=5 of frame 2, then flush coincident with wrap
        do_reset();
        run_frames(32, 21, 1'b0);
        flush_drain();
        run_frames(16, 15, 1'b0);
        flush_drain();

        // extra sop at cnt=9 resyncs and restarts fill
        do_reset();
        run_frames(9, -1, 1'b0);
        step(1'b1, 1'b1, 1'b0, "resync",
             ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_sel(9)));
        for (int j = 1; j <= 16; j++)
            step(1'b1, j == 16, 1'b0, "refill",
                 ev(1'b1, 1'b1, 1'b1, 1'b0, j >= 15, j == 15, 1'b0, exp_sel(j % 16)));

        // samples without sop in IDLE are dropped with an error each
        do_reset();
        for (int j = 0; j < 3; j++)
            step(1'b1, 1'b0, 1'b0, "idle_err",
                 ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000));
        step(1'b0, 1'b0, 1'b0, "idle_hold",
             ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));

        // reset asserted at cnt=7, then a clean restart
        do_reset();
        run_frames(7, -1, 1'b0);
        sys_nrst = 1'b0;
        step(1'b1, 1'b0, 1'b0, "reset_mid",
             ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000));
        sys_nrst = 1'b1;
        run_frames(16, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
